// File: rtl/axi_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axi_arb_pkg : shared encodings for the AXI read-channel arbiter   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package axi_arb_pkg;

  typedef enum logic [2:0] {
    R_IDLE = 3'b001,
    R_ADDR = 3'b010,
    R_DATA = 3'b100
  } rd_state_t;

  localparam logic [3:0] ARID_INST   = 4'd0;
  localparam logic [3:0] ARID_DATA   = 4'd1;
  localparam int         ARB_STATS_W = 3;

endpackage
`default_nettype wire

// File: rtl/axi_wr_tracker.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axi_wr_tracker : outstanding AXI write counter (aw up, b down)    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module axi_wr_tracker #(
  parameter int WCNT_W = 3
) (
  input  logic aclk,
  input  logic areset,
  input  logic aw_fire,
  input  logic b_fire,
  output logic wr_pending
);

  localparam logic [WCNT_W-1:0] c_cnt_max = '1;

  logic [WCNT_W-1:0] r_wr_cnt;
  logic              w_inc;
  logic              w_dec;

  assign w_inc = aw_fire & ~b_fire;
  assign w_dec = b_fire & ~aw_fire;

  // Illegal over/underflow holds the count; the assertions below report it.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wr_cnt <= '0;
    end else if (w_inc && (r_wr_cnt != c_cnt_max)) begin
      r_wr_cnt <= r_wr_cnt + WCNT_W'(1);
    end else if (w_dec && (r_wr_cnt != '0)) begin
      r_wr_cnt <= r_wr_cnt - WCNT_W'(1);
    end
  end

  assign wr_pending = (r_wr_cnt != '0);

  a_no_underflow: assert property (@(posedge aclk) disable iff (areset)
    !(w_dec && (r_wr_cnt == '0)));
  a_no_overflow: assert property (@(posedge aclk) disable iff (areset)
    !(w_inc && (r_wr_cnt == c_cnt_max)));

endmodule
`default_nettype wire

// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axi_rd_arbiter : shares one AXI3 AR/R pair between ifetch and     |
// | dcache; data reads wait for outstanding data writes to complete.  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module axi_rd_arbiter
  import axi_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int WCNT_W       = 3,
  parameter int ADDR_W       = 32
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [ADDR_W-1:0] i_araddr,
  input  logic [3:0]        i_arlen,
  input  logic [2:0]        i_arsize,
  input  logic              i_arvalid,
  output logic              i_arready,
  output logic              i_rvalid,
  input  logic [ADDR_W-1:0] d_araddr,
  input  logic [3:0]        d_arlen,
  input  logic [2:0]        d_arsize,
  input  logic              d_arvalid,
  output logic              d_arready,
  output logic              d_rvalid,
  output logic [31:0]       s_rdata,
  output logic              s_rlast,
  output logic [3:0]        m_arid,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [3:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [31:0]       m_rdata,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic              m_awvalid,
  input  logic              m_awready,
  input  logic              m_bvalid,
  input  logic              m_bready
);

  localparam logic [ARB_STATS_W-1:0] c_starve_max = ARB_STATS_W'(STARVE_LIMIT);

  rd_state_t               r_state;
  rd_state_t               w_state_nxt;
  logic                    r_owner;        // 1 = data side owns the burst
  logic [ARB_STATS_W-1:0]  r_starve_cnt;
  logic [3:0]              r_arid;
  logic [ADDR_W-1:0]       r_araddr;
  logic [3:0]              r_arlen;
  logic [2:0]              r_arsize;
  logic                    w_wr_pending;
  logic                    w_aw_fire;
  logic                    w_d_elig;
  logic                    w_i_win;
  logic                    w_d_win;
  logic                    w_grant_i;
  logic                    w_grant_d;

  axi_wr_tracker #(
    .WCNT_W (WCNT_W)
  ) u_wr_tracker (
    .aclk       (aclk),
    .areset     (areset),
    .aw_fire    (w_aw_fire),
    .b_fire     (m_bvalid & m_bready),
    .wr_pending (w_wr_pending)
  );

  // A write accepted this very cycle already blocks a data read.
  assign w_aw_fire = m_awvalid & m_awready;
  assign w_d_elig  = d_arvalid & ~w_wr_pending & ~w_aw_fire;
  assign w_i_win   = i_arvalid & (~w_d_elig | (r_starve_cnt == c_starve_max));
  assign w_d_win   = w_d_elig & ~w_i_win;

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state      <= R_IDLE;
      r_owner      <= 1'b0;
      r_starve_cnt <= '0;
      r_arid       <= '0;
      r_araddr     <= '0;
      r_arlen      <= '0;
      r_arsize     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_i) begin
        r_owner      <= 1'b0;
        r_arid       <= ARID_INST;
        r_araddr     <= i_araddr;
        r_arlen      <= i_arlen;
        r_arsize     <= i_arsize;
        r_starve_cnt <= '0;
      end else if (w_grant_d) begin
        r_owner  <= 1'b1;
        r_arid   <= ARID_DATA;
        r_araddr <= d_araddr;
        r_arlen  <= d_arlen;
        r_arsize <= d_arsize;
        if (i_arvalid && (r_starve_cnt != c_starve_max)) begin
          r_starve_cnt <= r_starve_cnt + ARB_STATS_W'(1);
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_i   = 1'b0;
    w_grant_d   = 1'b0;
    i_arready   = 1'b0;
    d_arready   = 1'b0;
    i_rvalid    = 1'b0;
    d_rvalid    = 1'b0;
    s_rdata     = '0;
    s_rlast     = 1'b0;
    if (!areset) begin
      case (r_state)
        R_IDLE: begin
          if (w_i_win) begin
            w_grant_i   = 1'b1;
            i_arready   = 1'b1;
            w_state_nxt = R_ADDR;
          end else if (w_d_win) begin
            w_grant_d   = 1'b1;
            d_arready   = 1'b1;
            w_state_nxt = R_ADDR;
          end
        end
        R_ADDR: begin
          if (m_arready) w_state_nxt = R_DATA;
        end
        R_DATA: begin
          s_rdata  = m_rdata;
          s_rlast  = m_rlast;
          i_rvalid = m_rvalid & ~r_owner;
          d_rvalid = m_rvalid & r_owner;
          if (m_rvalid && m_rlast) w_state_nxt = R_IDLE;
        end
        default: w_state_nxt = R_IDLE;
      endcase
    end
  end

  assign m_arvalid = (r_state == R_ADDR);
  assign m_arid    = r_arid;
  assign m_araddr  = r_araddr;
  assign m_arlen   = r_arlen;
  assign m_arsize  = r_arsize;
  assign m_rready  = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_axi_rd_arbiter : scoreboard bench for axi_rd_arbiter           |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_axi_rd_arbiter;

  typedef struct { bit side; int mode; } grant_t;   // mode 0 any, 1 after rlast, 2 after b
  typedef struct { logic [3:0] id; logic [31:0] addr; logic [3:0] len; logic [2:0] size; } ar_t;
  typedef struct { bit side; logic [31:0] data; bit last; } beat_t;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] i_araddr, d_araddr, m_araddr, s_rdata, m_rdata;
  logic [3:0]  i_arlen, d_arlen, m_arlen, m_arid;
  logic [2:0]  i_arsize, d_arsize, m_arsize;
  logic        i_arvalid, i_arready, i_rvalid, d_arvalid, d_arready, d_rvalid;
  logic        s_rlast, m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
  logic        m_awvalid, m_awready, m_bvalid, m_bready;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rlast_cyc = -100;
  int b_cyc = -100;
  int beats_seen = 0;
  int ar_delay = 0;

  grant_t grant_q[$];
  ar_t    ar_q[$];
  beat_t  beat_q[$];

  axi_rd_arbiter #(.STARVE_LIMIT(4), .WCNT_W(3), .ADDR_W(32)) u_dut (
    .aclk(aclk), .areset(areset),
    .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize), .i_arvalid(i_arvalid),
    .i_arready(i_arready), .i_rvalid(i_rvalid),
    .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize), .d_arvalid(d_arvalid),
    .d_arready(d_arready), .d_rvalid(d_rvalid),
    .s_rdata(s_rdata), .s_rlast(s_rlast),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  initial forever begin
    #5 aclk = 1'b1; cyc++;
    #5 aclk = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push_req(input bit side, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input int mode, input int nbeats);
    grant_q.push_back('{side: side, mode: mode});
    ar_q.push_back('{id: (side ? 4'd1 : 4'd0), addr: addr, len: len, size: size});
    for (int k = 0; k < nbeats; k++)
      beat_q.push_back('{side: side, data: addr + k, last: (k == int'(len))});
  endtask

  task automatic do_req(input bit side, input logic [31:0] addr, input logic [3:0] len,
                        input logic [2:0] size, output int waited);
    bit got = 0;
    waited = 0;
    if (side) begin d_araddr = addr; d_arlen = len; d_arsize = size; d_arvalid = 1'b1; end
    else      begin i_araddr = addr; i_arlen = len; i_arsize = size; i_arvalid = 1'b1; end
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge aclk);
      if (side ? d_arready : i_arready) got = 1;
      else waited++;
    end
    @(posedge aclk); #1;
    if (side) begin d_arvalid = 1'b0; d_araddr = 32'hDEAD_0000; d_arlen = 4'hF; end
    else      begin i_arvalid = 1'b0; i_araddr = 32'hDEAD_0001; i_arlen = 4'hF; end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL grant_timeout side=%0d actual=no_grant required=grant", side);
    end else begin
      @(negedge aclk);
      if (!m_arvalid || m_arid !== (side ? 4'd1 : 4'd0)) begin
        errors++;
        $display("FAIL ar_latency side=%0d actual arvalid=%0b arid=%0d required arvalid=1 arid=%0d",
                 side, m_arvalid, m_arid, side);
      end
    end
  endtask

  task automatic pulse_aw();
    m_awvalid = 1'b1; m_awready = 1'b1;
    @(posedge aclk); #1;
    m_awvalid = 1'b0; m_awready = 1'b0;
  endtask

  task automatic pulse_b();
    m_bvalid = 1'b1; m_bready = 1'b1;
    @(posedge aclk); #1;
    m_bvalid = 1'b0; m_bready = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((grant_q.size() != 0 || ar_q.size() != 0 || beat_q.size() != 0 || m_arvalid) && n < 400) begin
      @(posedge aclk); n++;
    end
    repeat (2) @(posedge aclk);
    #1;
    checks++;
    if (grant_q.size() != 0 || ar_q.size() != 0 || beat_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain actual grants=%0d ars=%0d beats=%0d left required 0 0 0",
               name, grant_q.size(), ar_q.size(), beat_q.size());
    end
  endtask

  initial begin
    int w;
    logic [31:0] sl_addr;
    logic [3:0]  sl_len, sl_beat;
    int sl_phase, sl_wait;
    bit prev_pend;
    ar_t    p_ar, ea;
    grant_t eg;
    beat_t  eb;

    areset = 1'b1;
    i_araddr = 32'h1111_0000; i_arlen = 4'd2; i_arsize = 3'd2; i_arvalid = 1'b1;
    d_araddr = 32'h2222_0000; d_arlen = 4'd2; d_arsize = 3'd2; d_arvalid = 1'b1;
    m_arready = 0; m_rdata = 0; m_rlast = 0; m_rvalid = 0;
    m_awvalid = 0; m_awready = 0; m_bvalid = 0; m_bready = 0;
    sl_phase = 0; sl_wait = 0; sl_addr = 0; sl_len = 0; sl_beat = 0; prev_pend = 0;

    fork
      forever begin : monitor
        @(negedge aclk);
        if (areset) begin
          prev_pend = 0;
        end else begin
          if (i_rvalid || d_rvalid) begin
            checks++;
            beats_seen++;
            if (i_rvalid && d_rvalid) begin
              errors++; $display("FAIL rvalid_both actual=1 1 required one side");
            end else if (beat_q.size() == 0) begin
              errors++; $display("FAIL unexpected_beat side=%0d data=%h required none", d_rvalid, s_rdata);
            end else begin
              eb = beat_q.pop_front();
              if (d_rvalid != eb.side || s_rdata !== eb.data || s_rlast !== eb.last) begin
                errors++;
                $display("FAIL beat actual side=%0d data=%h last=%0b required side=%0d data=%h last=%0b",
                         d_rvalid, s_rdata, s_rlast, eb.side, eb.data, eb.last);
              end
            end
            if (s_rlast) rlast_cyc = cyc;
          end
          if (prev_pend) begin
            checks++;
            if (!m_arvalid || m_arid !== p_ar.id || m_araddr !== p_ar.addr ||
                m_arlen !== p_ar.len || m_arsize !== p_ar.size) begin
              errors++;
              $display("FAIL ar_stable actual v=%0b addr=%h len=%0d required v=1 addr=%h len=%0d",
                       m_arvalid, m_araddr, m_arlen, p_ar.addr, p_ar.len);
            end
          end
          if (m_arvalid && m_arready) begin
            checks++;
            if (ar_q.size() == 0) begin
              errors++; $display("FAIL unexpected_ar addr=%h required none", m_araddr);
            end else begin
              ea = ar_q.pop_front();
              if (m_arid !== ea.id || m_araddr !== ea.addr || m_arlen !== ea.len || m_arsize !== ea.size) begin
                errors++;
                $display("FAIL ar_fields actual id=%0d addr=%h len=%0d size=%0d required id=%0d addr=%h len=%0d size=%0d",
                         m_arid, m_araddr, m_arlen, m_arsize, ea.id, ea.addr, ea.len, ea.size);
              end
            end
          end
          if (i_arready || d_arready) begin
            checks++;
            if ((i_arready && d_arready) || m_arvalid) begin
              errors++;
              $display("FAIL grant_conflict actual i=%0b d=%0b arvalid=%0b required single grant while idle",
                       i_arready, d_arready, m_arvalid);
            end else if (grant_q.size() == 0) begin
              errors++; $display("FAIL unexpected_grant side=%0d required none", d_arready);
            end else begin
              eg = grant_q.pop_front();
              if (d_arready != eg.side) begin
                errors++; $display("FAIL grant_side actual=%0d required=%0d", d_arready, eg.side);
              end else if (eg.mode == 1 && cyc != rlast_cyc + 1) begin
                errors++; $display("FAIL grant_bubble actual cyc=%0d required cyc=%0d", cyc, rlast_cyc + 1);
              end else if (eg.mode == 2 && cyc != b_cyc + 1) begin
                errors++; $display("FAIL grant_after_b actual cyc=%0d required cyc=%0d", cyc, b_cyc + 1);
              end
            end
          end
          prev_pend = m_arvalid && !m_arready;
          p_ar = '{id: m_arid, addr: m_araddr, len: m_arlen, size: m_arsize};
          if (m_bvalid && m_bready) b_cyc = cyc;
        end
      end
      forever begin : slave
        @(posedge aclk); #1;
        m_arready = 0; m_rvalid = 0; m_rlast = 0; m_rdata = 0;
        if (areset) begin
          sl_phase = 0;
        end else begin
          if (sl_phase == 0 && m_arvalid) begin sl_phase = 1; sl_wait = ar_delay; end
          if (sl_phase == 1) begin
            if (sl_wait == 0) begin
              m_arready = 1; sl_addr = m_araddr; sl_len = m_arlen; sl_beat = 0; sl_phase = 2;
            end else sl_wait--;
          end else if (sl_phase == 2) begin
            m_rvalid = 1; m_rdata = sl_addr + 32'(sl_beat); m_rlast = (sl_beat == sl_len);
            if (m_rlast) sl_phase = 0; else sl_beat++;
          end
        end
      end
    join_none

    // Reset state with both requesters asserting.
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_i_arready", 32'(i_arready), 0);
    chk("rst_d_arready", 32'(d_arready), 0);
    chk("rst_m_arvalid", 32'(m_arvalid), 0);
    chk("rst_m_rready", 32'(m_rready), 1);
    chk("rst_m_araddr", m_araddr, 0);
    chk("rst_m_arid_len", {m_arid, m_arlen}, 0);
    i_arvalid = 0; d_arvalid = 0;
    @(posedge aclk); #1 areset = 1'b0;
    @(posedge aclk); #1;

    // Instruction-only burst.
    push_req(0, 32'hBFC0_0000, 4'd3, 3'd2, 0, 4);
    do_req(0, 32'hBFC0_0000, 4'd3, 3'd2, w);
    chk("i_only_wait", 32'(w), 0);
    drain("i_only");

    // Simultaneous requests: data first, then instruction after the bubble.
    @(posedge aclk); #1;
    push_req(1, 32'h8000_1000, 4'd1, 3'd2, 0, 2);
    push_req(0, 32'hBFC0_0040, 4'd3, 3'd2, 1, 4);
    fork
      begin int w1; do_req(1, 32'h8000_1000, 4'd1, 3'd2, w1); end
      begin int w2; do_req(0, 32'hBFC0_0040, 4'd3, 3'd2, w2); end
    join
    drain("simul");

    // Starvation: i held while d requests back-to-back; i wins 5th arbitration.
    @(posedge aclk); #1;
    for (int k = 0; k < 4; k++) push_req(1, 32'h8000_2000 + 32'(k * 256), 4'd1, 3'd2, (k == 0) ? 0 : 1, 2);
    push_req(0, 32'hBFC0_0080, 4'd0, 3'd2, 1, 1);
    push_req(1, 32'h8000_2400, 4'd1, 3'd2, 1, 2);
    fork
      begin int w3; do_req(0, 32'hBFC0_0080, 4'd0, 3'd2, w3); end
      begin
        for (int k = 0; k < 5; k++) begin
          int w4;
          do_req(1, 32'h8000_2000 + 32'(k * 256), 4'd1, 3'd2, w4);
        end
      end
    join
    drain("starve");

    // Outstanding write blocks data reads until b; instruction reads pass.
    @(posedge aclk); #1;
    push_req(0, 32'hBFC0_00C0, 4'd1, 3'd2, 0, 2);
    push_req(0, 32'hBFC0_0100, 4'd0, 3'd2, 1, 1);
    push_req(1, 32'h8000_3000, 4'd2, 3'd1, 2, 3);
    fork
      pulse_aw();
      begin int w5; do_req(1, 32'h8000_3000, 4'd2, 3'd1, w5); end
      begin
        int w6;
        do_req(0, 32'hBFC0_00C0, 4'd1, 3'd2, w6);
        do_req(0, 32'hBFC0_0100, 4'd0, 3'd2, w6);
        repeat (6) @(posedge aclk);
        #1 pulse_b();
      end
    join
    drain("wr_block");

    // Address phase stalled 5 cycles; fields hold, no other grant.
    @(posedge aclk); #1;
    ar_delay = 5;
    push_req(1, 32'h8000_4000, 4'd0, 3'd0, 0, 1);
    push_req(0, 32'hBFC0_0140, 4'd1, 3'd2, 1, 2);
    fork
      begin int w7; do_req(1, 32'h8000_4000, 4'd0, 3'd0, w7); end
      begin int w8; do_req(0, 32'hBFC0_0140, 4'd1, 3'd2, w8); end
    join
    drain("ar_stall");
    ar_delay = 0;

    // Reset mid-burst with a write outstanding.
    @(posedge aclk); #1;
    pulse_aw();
    w = beats_seen;
    push_req(0, 32'hBFC0_0180, 4'd3, 3'd2, 0, 2);
    begin
      int w9, base, n;
      base = w;
      do_req(0, 32'hBFC0_0180, 4'd3, 3'd2, w9);
      n = 0;
      while (beats_seen < base + 2 && n < 50) begin @(posedge aclk); n++; end
      chk("rst_mid_beats", 32'(beats_seen - base), 2);
    end
    #2 areset = 1'b1;
    @(negedge aclk);
    chk("rst_mid_rvalid_gated", {31'(i_rvalid), d_rvalid}, 0);
    @(posedge aclk); #2 areset = 1'b0;
    @(negedge aclk);
    chk("post_rst_valids", {27'(i_rvalid), d_rvalid, i_arready, d_arready, m_arvalid}, 0);
    chk("post_rst_m_rready", 32'(m_rready), 1);
    chk("post_rst_m_araddr", m_araddr, 0);
    chk("post_rst_m_arid", 32'(m_arid), 0);
    @(posedge aclk); #1;
    push_req(1, 32'h8000_5000, 4'd1, 3'd2, 0, 2);
    do_req(1, 32'h8000_5000, 4'd1, 3'd2, w);
    chk("post_rst_d_wait", 32'(w), 0);
    drain("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares the core's single AXI3 read-address/read-data channel pair between the instruction-fetch requester (i_) and the data-cache requester (d_).
- Only one read burst is in flight at a time.
- The write channel is wired directly from the data side to AXI. This block only monitors the write channel, so that a data read never overtakes an outstanding data write.
- Sits between the icache/dcache AXI engines and the top-level AXI master port.

Parameters:
- STARVE_LIMIT, 4, consecutive arbitrations i_ may lose to d_ before i_ is forced to win.
- WCNT_W, 3, width of the outstanding-write counter.
- ADDR_W, 32, address width.

Ports:
- aclk  in  1  clock, all logic on rising edge
- areset  in  1  synchronous reset, active-high
- i_araddr  in  32  instruction read address
- i_arlen  in  4  instruction burst length minus 1
- i_arsize  in  3  instruction beat size
- i_arvalid  in  1  instruction read request
- i_arready  out  1  instruction request accepted (one-cycle pulse)
- i_rvalid  out  1  instruction read beat valid
- d_araddr  in  32  data read address
- d_arlen  in  4  data burst length minus 1
- d_arsize  in  3  data beat size
- d_arvalid  in  1  data read request
- d_arready  out  1  data request accepted (one-cycle pulse)
- d_rvalid  out  1  data read beat valid
- s_rdata  out  32  read data, broadcast to both requesters
- s_rlast  out  1  last beat, broadcast
- m_arid  out  4  0 = instruction, 1 = data
- m_araddr  out  32  AXI read address
- m_arlen  out  4  AXI burst length
- m_arsize  out  3  AXI beat size
- m_arvalid  out  1  AXI read address valid
- m_arready  in  1  AXI read address ready
- m_rdata  in  32  AXI read data
- m_rlast  in  1  AXI last beat
- m_rvalid  in  1  AXI read data valid
- m_rready  out  1  constant 1
- m_awvalid  in  1  monitored AXI write address valid
- m_awready  in  1  monitored AXI write address ready
- m_bvalid  in  1  monitored AXI write response valid
- m_bready  in  1  monitored AXI write response ready

Behaviour:
- Reset values (areset=1):
  - State is R_IDLE; owner=0; starve_cnt=0; wr_cnt=0.
  - All valid/ready outputs are 0, except m_rready=1.
  - m_ar* fields are 0.
  - Reset mid-burst abandons the transfer and does not wait for rlast.
- States are one-hot, 3 bits: R_IDLE, R_ADDR, R_DATA.
- R_IDLE:
  - Eligibility: d_ is eligible when d_arvalid is high, wr_cnt==0, and there is no aw handshake this cycle. i_ is eligible when i_arvalid is high.
  - Arbitration when both are eligible: d_ wins unless starve_cnt==STARVE_LIMIT, in which case i_ wins.
  - When one side wins: pulse the winner's x_arready this cycle; latch addr/len/size into the m_ar* registers; set owner; set m_arid; go to R_ADDR.
  - No eligible requester: stay in R_IDLE.
- Starvation counter:
  - starve_cnt increments when d_ wins while i_arvalid is high.
  - starve_cnt clears whenever i_ wins.
  - starve_cnt saturates at STARVE_LIMIT.
- R_ADDR:
  - m_arvalid=1 with the latched fields held stable.
  - On m_arready: go to R_DATA, m_arvalid=0 next cycle.
- R_DATA:
  - s_rdata=m_rdata and s_rlast=m_rlast, combinational.
  - The owner's x_rvalid = m_rvalid; the other side's rvalid is 0.
  - On m_rvalid && m_rlast: go to R_IDLE.
  - The earliest next grant is the following cycle, so there is a 1-cycle bubble between bursts.
- Latency: request to m_arvalid is 1 cycle. The first data beat is forwarded in the same cycle it arrives.
- wr_cnt:
  - Increments on m_awvalid&m_awready.
  - Decrements on m_bvalid&m_bready.
  - Both in the same cycle: unchanged.
  - A decrement at 0 and an increment at 2^WCNT_W-1 are illegal; they are flagged by simulation assertions, and the counter holds its value.
- i_ requests are never blocked by wr_cnt.
- The requester's x_araddr/len/size only need to be valid in its x_arready cycle; the block does not sample them afterwards.

Decomposition:
- Shared package axi_arb_pkg:
  - R_IDLE/R_ADDR/R_DATA one-hot encodings.
  - ARID_INST=4'd0 and ARID_DATA=4'd1.
  - ARB_STATS_W=3.
- Sub-module axi_wr_tracker: the wr_cnt up/down counter with a wr_pending output and the assertions.

Test Plan:
- i_ only: i_arvalid with addr 0xBFC00000 and arlen 3 → i_arready at T0, m_arvalid at T1 with m_arid=0; 4 beats on i_rvalid; d_rvalid stays 0.
- Simultaneous i_ and d_ requests with wr_cnt=0 → d_ granted first (m_arid=1); i_ granted in the cycle after d_'s rlast+1.
- d_ requests back-to-back while i_arvalid is held → i_ is granted on the 5th arbitration (STARVE_LIMIT=4).
- aw handshake, then d_arvalid → no d_arready until the b handshake; d_arready in the cycle after bvalid&bready. i_ requests during this window are granted normally.
- m_arready held low for 5 cycles → m_araddr/len/size stay stable, m_arvalid stays 1, and no other grant occurs.
- areset asserted mid-R_DATA after 2 of 4 beats → next cycle: R_IDLE, all valid/ready outputs 0, wr_cnt=0; a new request is granted normally.
